// File: rtl/qam_symbol_gen.sv
// QAM symbol generator: counts rising edges of a tick input and emits one
// symbol per PERIOD edges, taken from a rotating pattern or a PRBS7 LFSR.
module qam_symbol_gen #(
    parameter int BITS_PER_SYM = 4,
    parameter int PERIOD       = 510,
    parameter int PAT_LEN      = 28,
    parameter logic [PAT_LEN-1:0] PAT_INIT = 28'h6CC1555
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable_cntr,
    input  logic                      run,
    input  logic                      mode,
    input  logic                      load_en,
    input  logic [PAT_LEN-1:0]        load_data,
    output logic [BITS_PER_SYM/2-1:0] sym_i,
    output logic [BITS_PER_SYM/2-1:0] sym_q,
    output logic                      data_change,
    output logic                      pattern_wrap
);

    localparam int NSYM = PAT_LEN / BITS_PER_SYM;
    localparam int IW   = (NSYM > 1) ? $clog2(NSYM) : 1;
    localparam int CW   = $clog2(PERIOD + 1);
    localparam int B    = BITS_PER_SYM;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_COUNT = 2'd1;
    localparam logic [1:0] S_EMIT  = 2'd2;

    localparam logic [IW-1:0] IDX_LAST  = IW'(NSYM - 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD);
    localparam logic [6:0]    LFSR_SEED = 7'h7F;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               prev_q;
    logic               mode_q, mode_d;
    logic [PAT_LEN-1:0] pat_q, pat_d;
    logic [IW-1:0]      idx_q, idx_d;
    logic [6:0]         lfsr_q, lfsr_d;
    logic [B-1:0]       symreg_q, symreg_d;
    logic               dc_q, dc_d;
    logic               wrap_q, wrap_d;

    logic               en_edge;
    logic [CW-1:0]      cnt_inc;
    logic [IW-1:0]      idx_nx;
    logic [PAT_LEN-1:0] pat_rot;
    logic [6:0]         lfsr_step;
    logic [B-1:0]       prbs_sym;

    // PRBS7 advanced B steps at once; first bit produced lands in the MSB.
    always_comb begin
        lfsr_step = lfsr_q;
        prbs_sym  = '0;
        for (int k = 0; k < B; k++) begin
            prbs_sym[B-1-k] = lfsr_step[6] ^ lfsr_step[5];
            lfsr_step = {lfsr_step[5:0], lfsr_step[6] ^ lfsr_step[5]};
        end
    end

    always_comb begin
        en_edge = enable_cntr & ~prev_q;
        cnt_inc = cnt_q + CW'(1);
        idx_nx  = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        pat_rot = (pat_q << B) | (pat_q >> (PAT_LEN - B));

        state_d  = state_q;
        cnt_d    = cnt_q;
        mode_d   = mode_q;
        pat_d    = pat_q;
        idx_d    = idx_q;
        lfsr_d   = lfsr_q;
        symreg_d = symreg_q;
        dc_d     = 1'b0;
        wrap_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (load_en) begin
                    pat_d    = load_data;
                    idx_d    = '0;
                    lfsr_d   = LFSR_SEED;
                    symreg_d = load_data[PAT_LEN-1 -: B];
                end
                if (run) begin
                    state_d = S_COUNT;
                    mode_d  = mode;
                end
            end
            S_COUNT: begin
                // Dropping run beats a coincident edge.
                if (!run) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (en_edge) begin
                    if (cnt_inc == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = S_EMIT;
                        dc_d    = 1'b1;
                        if (mode_q) begin
                            lfsr_d   = lfsr_step;
                            symreg_d = prbs_sym;
                        end else begin
                            pat_d    = pat_rot;
                            symreg_d = pat_rot[PAT_LEN-1 -: B];
                            idx_d    = idx_nx;
                            wrap_d   = (idx_nx == '0);
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
            end
            S_EMIT: begin
                state_d = run ? S_COUNT : S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            prev_q   <= 1'b0;
            mode_q   <= 1'b0;
            pat_q    <= PAT_INIT;
            idx_q    <= '0;
            lfsr_q   <= LFSR_SEED;
            symreg_q <= PAT_INIT[PAT_LEN-1 -: B];
            dc_q     <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            prev_q   <= enable_cntr;
            mode_q   <= mode_d;
            pat_q    <= pat_d;
            idx_q    <= idx_d;
            lfsr_q   <= lfsr_d;
            symreg_q <= symreg_d;
            dc_q     <= dc_d;
            wrap_q   <= wrap_d;
        end
    end

    assign sym_i        = symreg_q[B-1:B/2];
    assign sym_q        = symreg_q[B/2-1:0];
    assign data_change  = dc_q;
    assign pattern_wrap = wrap_q;

endmodule

// File: tb/tb_qam_symbol_gen.sv
// Bench for qam_symbol_gen: directed scenarios plus randomized traffic
// checked every cycle against a symbol-list / bit-sequence model.
module tb_qam_symbol_gen;

    localparam int B = 4;
    localparam int PER = 4;
    localparam int L = 28;
    localparam int NS = L / B;
    localparam logic [27:0] INIT = 28'h6CC1555;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic        run = 1'b0;
    logic        mode = 1'b0;
    logic        ld = 1'b0;
    logic [27:0] ldd = '0;
    logic [1:0]  sym_i, sym_q;
    logic        dc, wrap;

    int tests = 0;
    int fails = 0;

    qam_symbol_gen #(
        .BITS_PER_SYM(B),
        .PERIOD(PER),
        .PAT_LEN(L),
        .PAT_INIT(INIT)
    ) dut (
        .clock(clk),
        .reset(rst_n),
        .enable_cntr(en),
        .run(run),
        .mode(mode),
        .load_en(ld),
        .load_data(ldd),
        .sym_i(sym_i),
        .sym_q(sym_q),
        .data_change(dc),
        .pattern_wrap(wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Model: pattern held as a list of symbols plus a position; PRBS as a
    // precomputed 127-bit sequence plus a read pointer.
    int m_state;
    int m_cnt, m_r, m_bp, m_mode, m_sym, m_dc, m_wr;
    bit m_prev;
    int pat[NS];
    int seq[127];

    function automatic void build_seq();
        int a[134];
        for (int i = 0; i < 7; i++) a[i] = 1;
        for (int i = 7; i < 134; i++) a[i] = a[i-7] ^ a[i-6];
        for (int i = 0; i < 127; i++) seq[i] = a[i+7];
    endfunction

    function automatic void load_pat(input logic [27:0] v);
        for (int i = 0; i < NS; i++)
            pat[i] = int'((v >> (L - B * (i + 1))) & 28'hF);
    endfunction

    function automatic void model_reset();
        m_state = 0;
        m_cnt = 0;
        m_prev = 0;
        m_r = 0;
        m_bp = 0;
        m_mode = 0;
        load_pat(INIT);
        m_sym = pat[0];
        m_dc = 0;
        m_wr = 0;
    endfunction

    function automatic void model_step(input bit e, input bit rn, input bit md,
                                       input bit l, input logic [27:0] d);
        bit edge_seen;
        edge_seen = e && !m_prev;
        m_prev = e;
        m_dc = 0;
        m_wr = 0;
        case (m_state)
            0: begin
                m_cnt = 0;
                if (l) begin
                    load_pat(d);
                    m_r = 0;
                    m_bp = 0;
                    m_sym = pat[0];
                end
                if (rn) begin
                    m_state = 1;
                    m_mode = md;
                end
            end
            1: begin
                if (!rn) begin
                    m_state = 0;
                    m_cnt = 0;
                end else if (edge_seen) begin
                    m_cnt++;
                    if (m_cnt == PER) begin
                        m_cnt = 0;
                        m_state = 2;
                        m_dc = 1;
                        if (m_mode == 0) begin
                            m_r = (m_r + 1) % NS;
                            m_sym = pat[m_r];
                            m_wr = (m_r == 0);
                        end else begin
                            m_sym = 0;
                            for (int k = 0; k < B; k++)
                                m_sym = (m_sym << 1) | seq[(m_bp + k) % 127];
                            m_bp = (m_bp + B) % 127;
                        end
                    end
                end
            end
            default: m_state = rn ? 1 : 0;
        endcase
    endfunction

    task automatic tick(input bit e, input bit rn, input bit md, input bit l,
                        input logic [27:0] d);
        en = e;
        run = rn;
        mode = md;
        ld = l;
        ldd = d;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(e, rn, md, l, d);
        @(negedge clk);
        check("sym", {28'h0, sym_i, sym_q}, m_sym);
        check("data_change", {31'h0, dc}, m_dc);
        check("pattern_wrap", {31'h0, wrap}, m_wr);
    endtask

    task automatic run_symbol(input bit md, output logic [3:0] s,
                              output logic w, output int edges);
        bit done;
        done = 0;
        edges = 0;
        s = '0;
        w = 1'b0;
        for (int i = 0; i < 30 && !done; i++) begin
            tick(0, 1, md, 0, '0);
            tick(1, 1, md, 0, '0);
            edges++;
            if (dc) begin
                s = {sym_i, sym_q};
                w = wrap;
                done = 1;
            end
        end
        if (!done) check("symbol_timeout", {31'h0, dc}, 1);
    endtask

    logic [3:0] s;
    logic       w;
    int         e;
    int         exp_seq[6] = '{4'hC, 4'h1, 4'h5, 4'h5, 4'h5, 4'h6};

    initial begin
        build_seq();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        check("rst_sym", {28'h0, sym_i, sym_q}, 4'h6);
        check("rst_dc", {31'h0, dc}, 0);
        check("rst_wrap", {31'h0, wrap}, 0);
        rst_n = 1'b1;

        tick(0, 1, 0, 0, '0);
        run_symbol(0, s, w, e);
        check("pat_first", s, 4'hC);
        check("pat_edges", e, PER);
        for (int i = 0; i < 6; i++) begin
            run_symbol(0, s, w, e);
            check("pat_seq", s, exp_seq[i]);
            check("pat_wrap", {31'h0, w}, (i == 5) ? 1 : 0);
        end

        tick(0, 0, 0, 0, '0);
        tick(0, 0, 0, 1, INIT);
        tick(0, 1, 1, 0, '0);
        run_symbol(1, s, w, e);
        check("prbs_first", s, 4'h0);
        check("prbs_nowrap", {31'h0, w}, 0);
        run_symbol(1, s, w, e);
        check("prbs_second", s, 4'h2);

        tick(0, 0, 0, 0, '0);
        tick(0, 1, 0, 0, '0);
        for (int i = 0; i < 10; i++) tick(1, 1, 0, 0, '0);
        run_symbol(0, s, w, e);
        check("held_edges", e, PER - 1);
        check("held_sym", s, 4'hC);

        tick(0, 1, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
        tick(0, 1, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
        tick(0, 1, 0, 0, '0);
        tick(1, 0, 0, 0, '0);
        check("runfall_dc", {31'h0, dc}, 0);
        check("runfall_sym", {28'h0, sym_i, sym_q}, 4'hC);
        tick(0, 1, 0, 0, '0);
        run_symbol(0, s, w, e);
        check("runfall_edges", e, PER);
        check("runfall_next", s, 4'hC);

        tick(0, 1, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
        tick(0, 1, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
        rst_n = 1'b0;
        #1;
        check("midrst_sym", {28'h0, sym_i, sym_q}, 4'h6);
        check("midrst_dc", {31'h0, dc}, 0);
        tick(0, 1, 0, 0, '0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) tick(i[0], 0, 0, 0, '0);
        check("postrst_sym", {28'h0, sym_i, sym_q}, 4'h6);

        tick(0, 1, 0, 0, '0);
        tick(1, 1, 0, 0, '0);
        tick(0, 1, 0, 1, 28'hFFFFFFF);
        run_symbol(0, s, w, e);
        check("ld_ignored", s, 4'hC);

        for (int i = 0; i < 1500; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            tick(1'($urandom_range(0, 1)), ($urandom_range(0, 9) != 0),
                 1'($urandom_range(0, 1)), ($urandom_range(0, 19) == 0),
                 28'($urandom()));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
